// File: rtl/versatile_fifo_sync_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port RAM.
// Define VERSATILE_FIFO_FWFT_EN for first-word-fall-through reads.
module versatile_fifo_sync_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_adr_a,
  output logic [ADDR_WIDTH-1:0] ram_adr_b,
  output logic [DATA_WIDTH-1:0] ram_d_a,
  output logic                  ram_we_a,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_d_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_WIDTH);
  localparam logic [CW-1:0] AFULL_LVL =
    CW'(2**ADDR_WIDTH - AFULL_MARGIN);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q, afull_q;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  valid_q, valid_d;
  logic                  pop_ok;
  logic                  push_acc, pop_acc;

`ifdef VERSATILE_FIFO_FWFT_EN
  logic                  pushed_q;
  logic [CW-1:0]         avail;

  // The word pushed at the last edge is not yet counted as the head.
  assign avail   = count_q - CW'(pop_acc) - CW'(pushed_q);
  assign pop_ok  = valid_q;
  assign valid_d = ~clear & (avail != '0);
  assign ram_adr_b = rd_ptr_q + ADDR_WIDTH'(pop_acc);
`else
  assign pop_ok  = ~empty_q;
  assign valid_d = pop_acc;
  assign ram_adr_b = rd_ptr_q;
`endif

  assign push_acc = push & ~full_q & ~clear;
  assign pop_acc  = pop & ~clear & pop_ok;

  assign wr_ptr_d = clear ? '0 : wr_ptr_q + ADDR_WIDTH'(push_acc);
  assign rd_ptr_d = clear ? '0 : rd_ptr_q + ADDR_WIDTH'(pop_acc);
  assign ovf_d = ~clear & (ovf_q | (push & full_q));
  assign unf_d = ~clear & (unf_q | (pop & ~pop_ok));

  // Fill count: both accepted leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      clear:               count_d = '0;
      push_acc & ~pop_acc: count_d = count_q + ONE;
      pop_acc & ~push_acc: count_d = count_q - ONE;
      default:             count_d = count_q;
    endcase
  end

  // Pointers, count, flags and read-valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH);
      afull_q  <= (count_d >= AFULL_LVL);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
    end
  end

`ifdef VERSATILE_FIFO_FWFT_EN
  // Remembers a push at the last edge for the head-visibility lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pushed_q <= 1'b0;
    else        pushed_q <= push_acc;
  end
`endif

  assign ram_we_a    = push_acc & rst_n;
  assign ram_adr_a   = wr_ptr_q;
  assign ram_d_a     = din;
  assign ram_we_b    = 1'b0;
  assign ram_d_b     = '0;
  assign dout        = ram_q_b;
  assign dout_valid  = valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_versatile_fifo_sync_ctrl.sv
// Randomised bench for versatile_fifo_sync_ctrl with a queue model.
// Honors VERSATILE_FIFO_FWFT_EN the same way as the design.
module tb_versatile_fifo_sync_ctrl;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int DEPTH = 512;
  localparam int AFM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout, ram_d_a, ram_d_b, ram_q_b;
  logic dout_valid, empty, full, almost_full;
  logic overflow, underflow, ram_we_a, ram_we_b;
  logic [AW:0] count;
  logic [AW-1:0] ram_adr_a, ram_adr_b;
  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  versatile_fifo_sync_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_MARGIN(AFM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid),
    .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_adr_a(ram_adr_a), .ram_adr_b(ram_adr_b),
    .ram_d_a(ram_d_a), .ram_we_a(ram_we_a),
    .ram_we_b(ram_we_b), .ram_d_b(ram_d_b),
    .ram_q_b(ram_q_b)
  );

  // Dual-port RAM with registered read, old data on collision.
  always_ff @(posedge clk) begin
    if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
    ram_q_b <= mem[ram_adr_b];
  end

  logic [DW-1:0] mq[$];
  int me[$];
  bit m_ovf, m_unf, m_valid;
  logic [DW-1:0] m_dout;
  int m_edge, m_wr;
  bit we_exp, we_seen;
  logic [AW-1:0] adr_exp, adr_seen;
  logic [DW-1:0] d_exp, d_seen;
  logic [23:0] dut_st;

  assign dut_st = {count, empty, full, almost_full,
                   overflow, underflow, dout_valid,
                   dout_valid ? dout : 8'h00};

  function automatic logic [23:0] exp_st();
    int n = mq.size();
    return {(AW+1)'(n), n == 0, n == DEPTH,
            n >= DEPTH - AFM, m_ovf, m_unf, m_valid,
            m_valid ? m_dout : 8'h00};
  endfunction

  task automatic model_reset();
    mq.delete();
    me.delete();
    m_ovf = 0;
    m_unf = 0;
    m_valid = 0;
    m_wr = 0;
  endtask

  task automatic model_edge(input bit p, o, c,
                            input logic [DW-1:0] d);
    int n = mq.size();
    bit pok, pa, oa;
`ifdef VERSATILE_FIFO_FWFT_EN
    pok = m_valid;
`else
    pok = (n != 0);
`endif
    pa = p && (n != DEPTH) && !c;
    oa = o && pok && !c;
    if (c) begin
      model_reset();
    end else begin
      if (p && n == DEPTH) m_ovf = 1;
      if (o && !pok) m_unf = 1;
      if (oa) begin
        m_dout = mq.pop_front();
        void'(me.pop_front());
      end
      if (pa) begin
        mq.push_back(d);
        me.push_back(m_edge);
        m_wr = (m_wr + 1) % DEPTH;
      end
    end
`ifdef VERSATILE_FIFO_FWFT_EN
    m_valid = 0;
    if (mq.size() != 0) begin
      if (me[0] <= m_edge - 2) begin
        m_valid = 1;
        m_dout = mq[0];
      end
    end
`else
    m_valid = oa;
`endif
    m_edge++;
  endtask

  task automatic cycle(input bit p, o, c,
                       input logic [DW-1:0] d);
    @(negedge clk);
    push = p;
    pop = o;
    clear = c;
    din = d;
    #2;
    we_exp = p && (mq.size() != DEPTH) && !c;
    adr_exp = AW'(m_wr);
    d_exp = d;
    we_seen = ram_we_a;
    adr_seen = ram_adr_a;
    d_seen = ram_d_a;
    @(posedge clk);
    model_edge(p, o, c, d);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (dut_st !== exp_st())
      $display("FAIL reset_state got %h want %h",
               dut_st, exp_st());
    checks++;
    if ({ram_we_b, ram_d_b} !== 9'h0)
      $display("FAIL port_b_const got %h want 0",
               {ram_we_b, ram_d_b});
    if ({ram_we_b, ram_d_b} !== 9'h0) errors++;
    if (dut_st !== exp_st()) errors++;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 0, DW'($urandom));
    @(negedge clk);
    push = 1'b1;
    din = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({count, empty, full, dout_valid, ram_we_a}
        !== {10'd0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_mid got %h want %h",
               {count, empty, full, dout_valid, ram_we_a},
               {10'd0, 4'b1000});
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (dut_st !== exp_st()) begin
      errors++;
      $display("FAIL reset_hold got %h want %h",
               dut_st, exp_st());
    end
    @(negedge clk);
    rst_n = 1'b1;
    push = 1'b0;
  endtask

  task automatic test_fill();
    cycle(0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, 0, 0, DW'(i));
      checks++;
      if ({we_seen, adr_seen, d_seen}
          !== {we_exp, adr_exp, d_exp}) begin
        errors++;
        $display("FAIL fill_ram got %h want %h",
                 {we_seen, adr_seen, d_seen},
                 {we_exp, adr_exp, d_exp});
      end
      checks++;
      if (dut_st !== exp_st()) begin
        errors++;
        $display("FAIL fill_st got %h want %h",
                 dut_st, exp_st());
      end
      if (i == 506 || i == 507) begin
        checks++;
        if (almost_full !== (i == 507)) begin
          errors++;
          $display("FAIL afull_edge got %b at %0d",
                   almost_full, i + 1);
        end
      end
    end
    cycle(1, 0, 0, 8'hEE);
    checks++;
    if ({we_seen, count, full, overflow}
        !== {1'b0, 10'd512, 2'b11}) begin
      errors++;
      $display("FAIL overflow got %h want %h",
               {we_seen, count, full, overflow},
               {1'b0, 10'd512, 2'b11});
    end
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_drain_wrap();
    cycle(0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < (k == 0 ? 300 : 400); i++)
        cycle(1, 0, 0, DW'($urandom));
      for (int i = 0; i < (k == 0 ? 300 : 400); i++) begin
        cycle(0, 1, 0, 0);
        checks++;
        if (dut_st !== exp_st() || dout_valid !== 1'b1) begin
          errors++;
          $display("FAIL drain got %h want %h",
                   dut_st, exp_st());
        end
      end
    end
    cycle(0, 1, 0, 0);
    checks++;
    if ({underflow, empty, dout_valid} !== 3'b110
        || dut_st !== exp_st()) begin
      errors++;
      $display("FAIL underflow got %h want %h",
               dut_st, exp_st());
    end
  endtask

  task automatic test_simultaneous();
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, DW'(i));
    cycle(1, 1, 0, 8'h55);
    checks++;
    if (count !== 10'd5 || dut_st !== exp_st()) begin
      errors++;
      $display("FAIL pp_cnt5 got %h want %h",
               dut_st, exp_st());
    end
    cycle(0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, DW'(i));
    cycle(1, 1, 0, 8'h66);
    checks++;
    if ({count, overflow} !== {10'd511, 1'b1}
        || dut_st !== exp_st()) begin
      errors++;
      $display("FAIL pp_full got %h want %h",
               dut_st, exp_st());
    end
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, DW'(i));
    cycle(1, 0, 1, 8'h99);
    checks++;
    if ({count, empty, we_seen} !== {10'd0, 2'b10}
        || dut_st !== exp_st()) begin
      errors++;
      $display("FAIL clr_push got %h want %h",
               dut_st, exp_st());
    end
  endtask

`ifdef VERSATILE_FIFO_FWFT_EN
  task automatic test_fwft();
    logic [1:0] v;
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 8'hA5);
    v[0] = dout_valid;
    cycle(0, 0, 0, 0);
    v[1] = dout_valid;
    checks++;
    if (v !== 2'b00) begin
      errors++;
      $display("FAIL fwft_early got %b want 00", v);
    end
    cycle(0, 0, 0, 0);
    checks++;
    if ({dout_valid, dout} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL fwft_first got %h want 1a5",
               {dout_valid, dout});
    end
    cycle(1, 0, 0, 8'h3C);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    checks++;
    if ({dout_valid, dout} !== {1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL fwft_next got %h want 13c",
               {dout_valid, dout});
    end
    cycle(0, 1, 0, 0);
    checks++;
    if (dout_valid !== 1'b0 || dut_st !== exp_st()) begin
      errors++;
      $display("FAIL fwft_last got %h want %h",
               dut_st, exp_st());
    end
  endtask
`else
  task automatic test_latency();
    logic v0;
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 8'h5A);
    v0 = dout_valid;
    cycle(0, 1, 0, 0);
    checks++;
    if ({v0, dout_valid, dout} !== {2'b01, 8'h5A}) begin
      errors++;
      $display("FAIL std_lat got %h want 15a",
               {v0, dout_valid, dout});
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL std_pulse got %b want 0", dout_valid);
    end
  endtask
`endif

  task automatic test_random();
    bit p, o, c, heavy;
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      heavy = ((i / 300) % 2) == 0;
      p = heavy ? ($urandom_range(0, 3) != 0)
                : ($urandom_range(0, 3) == 0);
      o = heavy ? ($urandom_range(0, 3) == 0)
                : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 299) == 0);
      cycle(p, o, c, DW'($urandom));
      checks++;
      if ({we_seen, adr_seen, d_seen}
          !== {we_exp, adr_exp, d_exp}) begin
        errors++;
        $display("FAIL rnd_ram got %h want %h",
                 {we_seen, adr_seen, d_seen},
                 {we_exp, adr_exp, d_exp});
      end
      checks++;
      if (dut_st !== exp_st()) begin
        errors++;
        $display("FAIL rnd_st got %h want %h",
                 dut_st, exp_st());
      end
    end
  endtask

  initial begin
    m_edge = 0;
    model_reset();
    test_reset();
    test_fill();
    test_drain_wrap();
    test_simultaneous();
`ifdef VERSATILE_FIFO_FWFT_EN
    test_fwft();
`else
    test_latency();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
